// File: rtl/seq_game_pkg.sv
// seq_game_pkg: shared types and constants for the pattern game blocks.
//   state_t     : player/checker FSM states
//   sym_t       : one 2-bit pattern symbol (legal values 0..2)
//   SYM_INVALID : the one 2-bit code that never appears in a legal pattern
//   DEFAULT_NUM_SYM : symbols per pattern unless overridden
//   max3        : helper used to size counters shared by several phases
package seq_game_pkg;

  localparam int DEFAULT_NUM_SYM = 9;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW,
    ST_GAP,
    ST_INPUT,
    ST_PASS,
    ST_FAIL
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter shared by the SHOW, GAP and INPUT phases.
//   clk     : system clock
//   reset_n : asynchronous reset, active-high
//   ld      : load strobe, count takes ld_val on the next edge
//   ld_val  : value to load
//   zero    : count is 0 (the counter saturates there until reloaded)
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      count_reg <= '0;
    end else if (ld) begin
      count_reg <= ld_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/seq_player_checker.sv
// seq_player_checker: captures a pattern of NUM_SYM 2-bit symbols, plays it to
// the display with timed show/gap phases, then checks the player's key presses
// against it in order and reports pass/fail and score.
//   clk, reset_n          : clock, asynchronous active-high reset
//   seq_in, load          : pattern word and its capture pulse
//   start                 : begin playback of the stored pattern
//   key_valid, key_val    : player entry pulse and symbol
//   disp_valid, disp_sym  : symbol currently displayed
//   busy, done, pass, fail: status for the game controller
//   seq_err               : pulse, a load carried an illegal symbol
//   score                 : correct entries in the current attempt
module seq_player_checker
  import seq_game_pkg::*;
#(
  parameter int NUM_SYM        = DEFAULT_NUM_SYM,
  parameter int SHOW_CYCLES    = 25000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [2*NUM_SYM-1:0]           seq_in,
  input  logic                           load,
  input  logic                           start,
  input  logic                           key_valid,
  input  logic [1:0]                     key_val,
  output logic                           disp_valid,
  output logic [1:0]                     disp_sym,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic                           fail,
  output logic                           seq_err,
  output logic [$clog2(NUM_SYM+1)-1:0]   score
);

  localparam int SEQ_W   = 2 * NUM_SYM;
  localparam int SCORE_W = $clog2(NUM_SYM + 1);
  localparam int IDX_W   = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
  localparam int MAX_CYC = max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Reload values are one less than the phase length: the phase ends on the
  // cycle the counter reads zero, so N loaded-as-(N-1) gives exactly N cycles.
  localparam logic [TMR_W-1:0] SHOW_LD    = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LD     = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SYM - 1);

  state_t             state_reg, state_next;
  logic [SEQ_W-1:0]   seq_reg, seq_next;
  logic               seq_loaded_reg, seq_loaded_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [SCORE_W-1:0] score_next;
  logic               seq_err_next;
  logic               tmr_ld;
  logic [TMR_W-1:0]   tmr_ld_val;
  logic               tmr_zero;
  logic [NUM_SYM-1:0] sym_bad;
  logic               load_bad;
  logic               ctl_ready;
  sym_t               cur_sym;
  sym_t               disp_sym_next;

  // Flag every symbol slot of the incoming word that holds the illegal code.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SYM; gi++) begin : g_sym_chk
      assign sym_bad[gi] = (seq_in[2*gi +: 2] == SYM_INVALID);
    end
  endgenerate

  assign load_bad  = |sym_bad;
  assign cur_sym   = seq_reg[2*idx_reg +: 2];
  assign ctl_ready = (state_reg == ST_IDLE) || (state_reg == ST_PASS) ||
                     (state_reg == ST_FAIL);

  phase_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (tmr_ld),
    .ld_val  (tmr_ld_val),
    .zero    (tmr_zero)
  );

  always_comb begin
    state_next      = state_reg;
    seq_next        = seq_reg;
    seq_loaded_next = seq_loaded_reg;
    idx_next        = idx_reg;
    score_next      = score;
    seq_err_next    = 1'b0;
    tmr_ld          = 1'b0;
    tmr_ld_val      = '0;

    if (ctl_ready) begin
      // A load in the same cycle as start always wins, even when rejected.
      if (load) begin
        if (load_bad) begin
          seq_err_next = 1'b1;
        end else begin
          seq_next        = seq_in;
          seq_loaded_next = 1'b1;
          state_next      = ST_IDLE;
        end
      end else if (start && seq_loaded_reg) begin
        idx_next   = '0;
        score_next = '0;
        tmr_ld     = 1'b1;
        tmr_ld_val = SHOW_LD;
        state_next = ST_SHOW;
      end
    end else begin
      case (state_reg)
        ST_SHOW: begin
          if (tmr_zero) begin
            tmr_ld     = 1'b1;
            tmr_ld_val = GAP_LD;
            state_next = ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
            tmr_ld = 1'b1;
            if (idx_reg < LAST_IDX) begin
              idx_next   = idx_reg + IDX_W'(1);
              tmr_ld_val = SHOW_LD;
              state_next = ST_SHOW;
            end else begin
              idx_next   = '0;
              tmr_ld_val = TIMEOUT_LD;
              state_next = ST_INPUT;
            end
          end
        end
        ST_INPUT: begin
          // A key on the timeout cycle is judged on its value, not timed out.
          if (key_valid) begin
            if (key_val == cur_sym) begin
              score_next = score + SCORE_W'(1);
              if (idx_reg == LAST_IDX) begin
                state_next = ST_PASS;
              end else begin
                idx_next   = idx_reg + IDX_W'(1);
                tmr_ld     = 1'b1;
                tmr_ld_val = TIMEOUT_LD;
              end
            end else begin
              state_next = ST_FAIL;
            end
          end else if (tmr_zero) begin
            state_next = ST_FAIL;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign disp_sym_next = (state_next == ST_SHOW) ? seq_next[2*idx_next +: 2] : 2'b00;

  // Outputs are registered from the next-state values so they line up with
  // the state they describe.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_reg      <= ST_IDLE;
      seq_reg        <= '0;
      seq_loaded_reg <= 1'b0;
      idx_reg        <= '0;
      disp_valid     <= 1'b0;
      disp_sym       <= 2'b00;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      seq_err        <= 1'b0;
      score          <= '0;
    end else begin
      state_reg      <= state_next;
      seq_reg        <= seq_next;
      seq_loaded_reg <= seq_loaded_next;
      idx_reg        <= idx_next;
      disp_valid     <= (state_next == ST_SHOW);
      disp_sym       <= disp_sym_next;
      busy           <= (state_next == ST_SHOW) || (state_next == ST_GAP) ||
                        (state_next == ST_INPUT);
      done           <= (state_next == ST_PASS) || (state_next == ST_FAIL);
      pass           <= (state_next == ST_PASS);
      fail           <= (state_next == ST_FAIL);
      seq_err        <= seq_err_next;
      score          <= score_next;
    end
  end

endmodule

// File: doc/seq_player_checker.md
Name: seq_player_checker

Overview:
- Downstream consumer of the 18-bit random pattern word: nine 2-bit symbols, each of value 0..2, with symbol 0 in bits [1:0].
- Captures one pattern and plays it symbol by symbol to the display logic using timed show/gap phases.
- Then accepts the player's key presses and compares them in order against the stored pattern.
- Reports pass/fail and score to the game controller.

Parameters:
NUM_SYM, 9, symbols per pattern; pattern width is 2*NUM_SYM.
SHOW_CYCLES, 25000000, cycles each symbol is displayed (>=1).
GAP_CYCLES, 12500000, blank cycles after each displayed symbol (>=1).
TIMEOUT_CYCLES, 250000000, maximum cycles allowed between key presses in the input phase (>=1).

Ports:
clk  in  1  system clock; all state updates on its rising edge.
reset_n  in  1  reset; asynchronous, active-high (asserted when 1).
seq_in  in  2*NUM_SYM  pattern word from the generator.
load  in  1  one-cycle pulse: capture seq_in.
start  in  1  one-cycle pulse: begin playback of the stored pattern.
key_valid  in  1  one-cycle pulse: key_val is a player entry.
key_val  in  2  entered symbol.
disp_valid  out  1  a symbol is being shown.
disp_sym  out  2  symbol being shown; 0 when disp_valid=0.
busy  out  1  state is SHOW, GAP or INPUT.
done  out  1  state is PASS or FAIL.
pass  out  1  state is PASS.
fail  out  1  state is FAIL.
seq_err  out  1  one-cycle pulse: a load was rejected.
score  out  $clog2(NUM_SYM+1)  number of correct entries in the current attempt.

Behaviour:
- Reset state: state IDLE; all outputs 0; seq_reg 0; seq_loaded 0; idx 0; timer 0.
- Reset is asynchronous and may occur mid-operation; it aborts all activity and returns to these values.
- States: IDLE, SHOW, GAP, INPUT, PASS, FAIL. All outputs are registered.
- Load, accepted in IDLE, PASS and FAIL:
  - If any symbol of seq_in equals 2'b11, the load is rejected: seq_err pulses 1 the next cycle and seq_reg is unchanged.
  - Otherwise seq_in is written to seq_reg, seq_loaded is set, and the state goes to IDLE.
  - Load is ignored in SHOW, GAP and INPUT.
- Start:
  - Acts only in IDLE, PASS or FAIL, and only when seq_loaded=1. Otherwise it is ignored.
  - Effect: idx=0, score=0, timer=SHOW_CYCLES-1, next state SHOW.
  - If load and start are asserted in the same cycle, load wins and start is dropped.
- SHOW:
  - disp_valid=1, disp_sym=seq_reg[2*idx+:2].
  - Timer decrements each cycle. At timer==0: state GAP, timer=GAP_CYCLES-1.
  - Each symbol is shown for exactly SHOW_CYCLES cycles.
- GAP:
  - disp_valid=0.
  - At timer==0:
    - If idx<NUM_SYM-1: idx++, timer=SHOW_CYCLES-1, state SHOW.
    - Otherwise: idx=0, timer=TIMEOUT_CYCLES-1, state INPUT.
- INPUT:
  - key_valid=1 and key_val==seq_reg[2*idx+:2]:
    - score++.
    - If idx==NUM_SYM-1, state PASS. Otherwise idx++ and the timer reloads to TIMEOUT_CYCLES-1.
  - key_valid=1 with a mismatch (including key_val=3): state FAIL, score unchanged.
  - No key while timer==0: state FAIL.
  - A key arriving in the same cycle as timer==0 is evaluated and takes priority over the timeout.
- Ignored keys: key_valid is ignored in IDLE, SHOW, GAP, PASS and FAIL. No buffering; early presses are lost.
- PASS/FAIL:
  - Held until start (replay the same pattern) or an accepted load (go to IDLE).
  - score is held through PASS/FAIL.
- Widths:
  - idx is $clog2(NUM_SYM) bits.
  - The timer width is $clog2 of the largest of the three cycle parameters.
  - There is no wrap: idx never exceeds NUM_SYM-1.

Decomposition:
- Shared package seq_game_pkg:
  - State enum.
  - sym_t (2-bit).
  - SYM_INVALID=2'b11.
  - Default NUM_SYM.
- Sub-module phase_timer:
  - Loadable down-counter with a load value, load strobe, and zero flag.
  - One instance, reused by SHOW, GAP and INPUT.

Test Plan:
Bench parameters: SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20, NUM_SYM=9. Bench pattern P: seq_in=18'b10_01_00_10_01_00_10_01_00, giving symbols 0,1,2,0,1,2,0,1,2.
- Load P, then start -> disp_sym sequence 0,1,2,0,1,2,0,1,2; each symbol disp_valid=1 for 4 cycles followed by 2 cycles at 0; 54 cycles total; then busy stays 1 in INPUT.
- Play P, then key 0,1,2,0,1,2,0,1,2 -> pass=1, done=1, score=9; a start pulse in PASS replays P from idx 0 with score=0.
- Play P, then keys 0,1,1 -> fail=1 after the third key, score=2; further key_valid pulses cause no change.
- Play P, key 0, then no key for 20 cycles -> fail=1, score=1. Separately: a key on the exact timeout cycle is accepted.
- Load with bits [5:4]=2'b11 -> seq_err pulses for 1 cycle, seq_reg unchanged. Start with no prior valid load -> stays IDLE.
- Assert reset_n mid-SHOW (at idx 4) -> all outputs 0 immediately, without waiting for a clock edge. After release, start is ignored until a new load.
